// File: rtl/cam_pkg.sv
// Shared types and default VGA RGB565 timing for the camera sensor emulator.
// Frame size is 784 pixel periods x 510 lines.
package cam_pkg;

    localparam int H_ACTIVE      = 640;
    localparam int V_ACTIVE      = 480;
    localparam int H_BLANK_BYTES = 288;
    localparam int V_SYNC_LINES  = 3;
    localparam int V_BACK_LINES  = 17;
    localparam int V_FRONT_LINES = 10;

    localparam int LINE_BYTES  = 2 * H_ACTIVE + H_BLANK_BYTES;
    localparam int FRAME_LINES = V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_COUNT = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Element 0 is the leftmost bar.
    localparam logic [7:0][15:0] BAR_COLOURS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational test-pattern generator: one RGB565 pixel from the
// pixel coordinates, the latched pattern and the frame/pixel counters.
module cam_pattern_pixel
    import cam_pkg::*;
(
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  pattern_e    pattern_i,
    input  logic [7:0]  frame_cnt_i,
    input  logic [15:0] pix_cnt_i,
    output logic [15:0] pixel_o
);

    logic [2:0] bar_idx;
    logic       unused_bits;

    assign unused_bits = ^{y_i[9], y_i[2:0], frame_cnt_i[7:5]};

    // Bars are 80 px wide; pick the lowest bar whose right edge lies beyond x.
    always_comb begin
        bar_idx = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if (x_i < 10'(80 * (k + 1))) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        pixel_o = 16'h0000;
        case (pattern_i)
            PAT_BARS:  pixel_o = BAR_COLOURS[bar_idx];
            PAT_RAMP:  pixel_o = {x_i[9:5], y_i[8:3], frame_cnt_i[4:0]};
            PAT_CHECK: pixel_o = (x_i[5] ^ y_i[5]) ? 16'hFFFF : 16'h0000;
            PAT_COUNT: pixel_o = pix_cnt_i;
            default:   pixel_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_sensor_emu.sv
// OV7670-style camera transmitter: PCLK = clk_i/2, with VSYNC/HREF/data
// registered on the clk_i edge where PCLK falls.
module cam_sensor_emu
    import cam_pkg::*;
#(
    parameter int H_ACT   = cam_pkg::H_ACTIVE,
    parameter int H_BLANK = cam_pkg::H_BLANK_BYTES,
    parameter int V_SYNC  = cam_pkg::V_SYNC_LINES,
    parameter int V_BACK  = cam_pkg::V_BACK_LINES,
    parameter int V_ACT   = cam_pkg::V_ACTIVE,
    parameter int V_FRONT = cam_pkg::V_FRONT_LINES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] pattern_i,
    output logic       cam_pclk,
    output logic       cam_vsync,
    output logic       cam_href,
    output logic [7:0] cam_data,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int LB = 2 * H_ACT + H_BLANK;
    localparam int FL = V_SYNC + V_BACK + V_ACT + V_FRONT;

    localparam logic [10:0] BYTE_LAST = 11'(LB - 1);
    localparam logic [10:0] HREF_END  = 11'(2 * H_ACT);
    localparam logic [9:0]  LINE_LAST = 10'(FL - 1);
    localparam logic [9:0]  VS_END    = 10'(V_SYNC);
    localparam logic [9:0]  ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  ACT_END   = 10'(V_SYNC + V_BACK + V_ACT);

    state_e      state_q, state_d;
    pattern_e    pat_q, pat_d;
    logic        pclk_q, pclk_d;
    logic [10:0] byte_q, byte_d;
    logic [9:0]  line_q, line_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        href_now;
    logic        frame_end;
    logic [9:0]  y_idx;
    logic [15:0] pixel;

    assign href_now  = (line_q >= ACT_START) && (line_q < ACT_END) && (byte_q < HREF_END);
    assign frame_end = (line_q == LINE_LAST) && (byte_q == BYTE_LAST);
    assign y_idx     = line_q - ACT_START;

    cam_pattern_pixel u_pixel (
        .x_i         (byte_q[10:1]),
        .y_i         (y_idx),
        .pattern_i   (pat_q),
        .frame_cnt_i (frame_cnt_q),
        .pix_cnt_i   (pix_cnt_q),
        .pixel_o     (pixel)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        pclk_d      = pclk_q;
        byte_d      = byte_q;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pclk_d = 1'b0;
                if (enable_i) begin
                    // Start with PCLK high so the very next edge is the first falling update.
                    state_d = ST_RUN;
                    pclk_d  = 1'b1;
                    busy_d  = 1'b1;
                    pat_d   = pattern_e'(pattern_i);
                end
            end
            ST_RUN: begin
                pclk_d = ~pclk_q;
                if (pclk_q) begin
                    vsync_d = (line_q < VS_END);
                    href_d  = href_now;
                    data_d  = href_now ? (byte_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
                    if (href_now && byte_q[0]) begin
                        pix_cnt_d = pix_cnt_q + 16'd1;
                    end
                    if (frame_end) begin
                        byte_d      = 11'd0;
                        line_d      = 10'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        pix_cnt_d   = 16'd0;
                        pat_d       = pattern_e'(pattern_i);
                        done_d      = 1'b1;
                        if (!enable_i) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (byte_q == BYTE_LAST) begin
                        byte_d = 11'd0;
                        line_d = line_q + 10'd1;
                    end else begin
                        byte_d = byte_q + 11'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            pat_q       <= PAT_BARS;
            pclk_q      <= 1'b0;
            byte_q      <= 11'd0;
            line_q      <= 10'd0;
            frame_cnt_q <= 8'd0;
            pix_cnt_q   <= 16'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            pclk_q      <= pclk_d;
            byte_q      <= byte_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cam_pclk     = pclk_q;
    assign cam_vsync    = vsync_q;
    assign cam_href     = href_q;
    assign cam_data     = data_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: doc/cam_sensor_emu.md
# cam_sensor_emu

Synthesizable OV7670-style camera sensor emulator: drives PCLK, VSYNC, HREF and 8-bit RGB565 byte data on the same interface the camera capture path receives. It is the transmitting end of the camera link. It replaces the physical sensor for on-board bring-up of the capture → SDRAM → Sobel → VGA chain, and serves as a deterministic stimulus source in simulation. Frame timing matches the sensor's VGA RGB565 mode: 784 pixel periods per line and 510 lines per frame.

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK_BYTES, 288: PCLK periods with HREF low per line.
- V_SYNC_LINES, 3: lines with VSYNC high.
- V_BACK_LINES, 17: lines from VSYNC fall to the first HREF.
- V_FRONT_LINES, 10: lines after the last HREF.

Ports:
- clk_i  in  1  System clock, 50 MHz.
- rst_ni  in  1  Asynchronous, active-low reset.
- enable_i  in  1  Level. Run frames while high.
- pattern_i  in  2  0 = colour bars, 1 = ramp, 2 = checker, 3 = pixel counter.
- cam_pclk  out  1  Pixel clock, clk_i/2.
- cam_vsync  out  1  Frame sync, active high.
- cam_href  out  1  Line valid, active high.
- cam_data  out  8  RGB565 byte.
- busy_o  out  1  High while a frame is in progress.
- frame_done_o  out  1  One-clk_i pulse at the end of each frame.

## Operation
- FSM states: IDLE and RUN.
  - IDLE → RUN when enable_i is high at a PCLK falling update.
  - RUN → IDLE at the end of a frame if enable_i is low; otherwise RUN restarts the next frame immediately.
  - enable_i falling mid-frame does not abort the current frame.
- pattern_i is latched at frame start. Changes mid-frame are ignored.
- Counters:
  - byte_cnt runs 0..LINE_BYTES-1, where LINE_BYTES = 2·H_ACTIVE + H_BLANK_BYTES = 1568.
  - line_cnt runs 0..509, where the total is V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES.
  - byte_cnt wraps to 0 and increments line_cnt. line_cnt wraps to 0 at the end of the frame.
  - frame_cnt is 8 bits, increments per frame, and wraps.
- cam_vsync = 1 for line_cnt < V_SYNC_LINES, which is 4704 PCLK periods.
- cam_href = 1 when both conditions hold:
  - line_cnt is in [V_SYNC_LINES+V_BACK_LINES, +V_ACTIVE).
  - byte_cnt < 2·H_ACTIVE.
- Pixel coordinates: x = byte_cnt>>1 (0..639) and y = active line index (0..479).
  - Even byte carries pixel[15:8]. Odd byte carries pixel[7:0].
- Patterns, as 16-bit RGB565:
  - 0, colour bars: 8 bars of 80 px in the order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, ramp: R = x[9:5], G = y[8:3], B = frame_cnt[4:0].
  - 2, checker: x[5]^y[5] ? FFFF : 0000.
  - 3, counter: 16-bit count that increments per pixel, cleared at frame start, and wraps.
- cam_data = 00 whenever cam_href = 0.

## Timing
- cam_pclk toggles every clk_i cycle while RUN. It is held at 0 in IDLE.
- cam_vsync, cam_href and cam_data are registered and update only on the clk_i edge where cam_pclk goes 1→0.
  - This gives one full clk_i of setup and hold around the PCLK rising edge, which is where the receiver samples.
- The first PCLK falling update after entering RUN presents line 0, byte 0, with cam_vsync rising.
- frame_done_o pulses in the cycle after the last byte of line 509.
  - busy_o falls in that same cycle if the FSM returns to IDLE.
- Reset values: cam_pclk, cam_vsync, cam_href, cam_data, busy_o and frame_done_o are all 0. All counters are 0 and the FSM is in IDLE.
- Reset asserted mid-frame clears everything at once. No partial line is completed.

## Structure
- Shared package cam_pkg holds:
  - pattern_e enum: PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_COUNT.
  - Default timing localparams (LINE_BYTES, FRAME_LINES).
  - The 8-entry bar colour constant array.
  - The state enum.
- Sub-module cam_pattern_pixel is combinational. Inputs are x, y, latched pattern, frame_cnt and pixel counter; output is the 16-bit pixel.
- Top level holds the FSM, the PCLK divider, the counters and the output registers.

## Test plan
- Reset with enable_i=1 → all outputs 0 while rst_ni=0. The first cam_vsync rise occurs within 2 clk_i of rst_ni release.
- One frame, pattern 0 →
  - Exactly 480 HREF pulses, each 1280 PCLK periods high and 288 low.
  - VSYNC high 4704 PCLK periods.
  - 17·1568 PCLK periods from VSYNC fall to the first HREF rise.
  - frame_done_o after 799,680 PCLK periods.
- Pattern 0 data → line 0 pixel 0 bytes FF,FF. Pixel 80 bytes FF,E0. Pixel 639 bytes 00,00.
- Pattern 3 → first pixel 00,00. Last pixel of the frame AF,FF (307199 mod 65536). Counter resets to 0000 on the next frame.
- enable_i dropped at line 200, with pattern_i switched to 2 at line 100 →
  - The frame completes with pattern 3 data throughout.
  - frame_done_o pulses.
  - FSM goes to IDLE with cam_pclk static at 0 and busy_o=0.
- rst_ni pulsed low at line 300, byte 500 → outputs 0 immediately. The next frame restarts at line 0 with a VSYNC rise.
